noc_traffic_source: RTL

//  Parametrised synthetic packet source for mesh NoC benches; drives one Router input port.

---
 rtl/router_pkg.sv | 40 ++++
 rtl/noc_traffic_source_if.sv | 14 +
 rtl/noc_lfsr16.sv | 27 ++
 rtl/noc_traffic_source.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared NoC router types: flit layout, flit/traffic enums and XY coordinate width.
// Also holds the traffic-source FSM state encoding and the LFSR tap mask.
package router_pkg;

    localparam int COORD_W = 4;

    // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        SINGLE = 2'd3
    } flit_type_t;

    typedef enum logic [1:0] {
        FIXED     = 2'd0,
        UNIFORM   = 2'd1,
        TRANSPOSE = 2'd2,
        BITCOMP   = 2'd3
    } traffic_mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2,
        S_DONE = 2'd3
    } src_state_t;

    typedef struct packed {
        flit_type_t           flit_type;
        logic [COORD_W-1:0]   dst_x;
        logic [COORD_W-1:0]   dst_y;
        logic [COORD_W-1:0]   src_x;
        logic [COORD_W-1:0]   src_y;
        logic [15:0]          payload;
    } FLIT_t;

endpackage

// File: rtl/noc_traffic_source_if.sv
// Flit link between a traffic source (master) and a router input port (slave).
// Handshake: a flit transfers on a rising clk edge where o_transmit && i_send;
// o_transmit is already gated by i_send, and o_flit stays stable while a flit is pending.
interface noc_traffic_source_if;
    import router_pkg::*;

    FLIT_t o_flit;
    logic  o_transmit;
    logic  i_send;

    modport master (output o_flit, output o_transmit, input i_send);
    modport slave  (input o_flit, input o_transmit, output i_send);

endinterface

// File: rtl/noc_lfsr16.sv
// 16-bit Galois LFSR used for injection decisions and uniform destinations.
module noc_lfsr16
    import router_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/noc_traffic_source.sv
// Synthetic multi-flit packet source for one router input port with a finite packet budget.
// Define TRAFFIC_GEN_STATS_EN for live o_pkt_cnt/o_stall_cnt; otherwise both read as zero.
module noc_traffic_source
    import router_pkg::*;
#(
    parameter int          XADDR    = 0,
    parameter int          YADDR    = 0,
    parameter int          MESH_X   = 4,
    parameter int          MESH_Y   = 4,
    parameter int          PKT_LEN  = 4,
    parameter int          NUM_PKTS = 16,
    parameter int          INJ_RATE = 128,
    parameter int          MODE     = 0,
    parameter int          FIXED_X  = 1,
    parameter int          FIXED_Y  = 0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    noc_traffic_source_if.master  link,
    output logic                  o_done,
    output logic [15:0]           o_pkt_cnt,
    output logic [15:0]           o_stall_cnt,
    output src_state_t            o_state_dbg
);

    localparam logic [COORD_W-1:0] X_MASK   = COORD_W'(MESH_X - 1);
    localparam logic [COORD_W-1:0] Y_MASK   = COORD_W'(MESH_Y - 1);
    localparam logic [COORD_W-1:0] SELF_X   = COORD_W'(XADDR);
    localparam logic [COORD_W-1:0] SELF_Y   = COORD_W'(YADDR);
    localparam logic [7:0]         LAST_IDX = 8'(PKT_LEN - 1);
    localparam traffic_mode_t      TMODE    = traffic_mode_t'(MODE[1:0]);

    src_state_t         state_q, state_d;
    logic [COORD_W-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [7:0]         idx_q, idx_d;
    logic [15:0]        seq_q, seq_d, sent_q, sent_d;
    logic [15:0]        lfsr;
    logic [COORD_W-1:0] rnd_x, rnd_y, gen_x, gen_y;
    logic               valid, xfer, inject, pkt_end;
    FLIT_t              flit;

    noc_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    assign valid  = (state_q == S_HEAD) || (state_q == S_BODY);
    assign xfer   = valid && link.i_send;
    assign inject = int'(lfsr[7:0]) < INJ_RATE;

    // Uniform picks that land on this node are bumped one column to the right.
    always_comb begin
        rnd_x = lfsr[8 +: COORD_W] & X_MASK;
        rnd_y = lfsr[12 +: COORD_W] & Y_MASK;
        if (rnd_x == SELF_X && rnd_y == SELF_Y) rnd_x = (rnd_x + COORD_W'(1)) & X_MASK;
        case (TMODE)
            UNIFORM:   begin gen_x = rnd_x;            gen_y = rnd_y;            end
            TRANSPOSE: begin gen_x = SELF_Y;           gen_y = SELF_X;           end
            BITCOMP:   begin gen_x = ~SELF_X & X_MASK; gen_y = ~SELF_Y & Y_MASK; end
            default:   begin gen_x = COORD_W'(FIXED_X); gen_y = COORD_W'(FIXED_Y); end
        endcase
    end

    always_comb begin
        flit = '0;
        if (valid) begin
            flit.dst_x = dst_x_q;
            flit.dst_y = dst_y_q;
            flit.src_x = SELF_X;
            flit.src_y = SELF_Y;
            if (state_q == S_HEAD) begin
                flit.flit_type = (PKT_LEN == 1) ? SINGLE : HEAD;
                flit.payload   = seq_q;
            end else begin
                flit.flit_type = (idx_q == LAST_IDX) ? TAIL : BODY;
                flit.payload   = {seq_q[7:0], idx_q};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dst_x_d = dst_x_q;
        dst_y_d = dst_y_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        sent_d  = sent_q;
        pkt_end = 1'b0;
        case (state_q)
            S_IDLE: if (i_start && inject) begin
                dst_x_d = gen_x;
                dst_y_d = gen_y;
                idx_d   = 8'd0;
                state_d = S_HEAD;
            end
            S_HEAD: if (xfer) begin
                if (PKT_LEN == 1) pkt_end = 1'b1;
                else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_BODY;
                end
            end
            S_BODY: if (xfer) begin
                if (idx_q == LAST_IDX) pkt_end = 1'b1;
                else                   idx_d   = idx_q + 8'd1;
            end
            default: state_d = S_DONE;
        endcase
        if (pkt_end) begin
            seq_d   = seq_q + 16'd1;
            sent_d  = sent_q + 16'd1;
            state_d = (NUM_PKTS != 0 && sent_q + 16'd1 == 16'(NUM_PKTS)) ? S_DONE : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dst_x_q <= '0;
            dst_y_q <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            dst_x_q <= dst_x_d;
            dst_y_q <= dst_y_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
        end
    end

`ifdef TRAFFIC_GEN_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (valid && !link.i_send && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    // The budget counter already tracks completed packets.
    assign o_pkt_cnt   = sent_q;
    assign o_stall_cnt = stall_q;
`else
    assign o_pkt_cnt   = 16'h0000;
    assign o_stall_cnt = 16'h0000;
`endif

    assign link.o_flit     = flit;
    assign link.o_transmit = xfer;
    assign o_done          = (state_q == S_DONE);
    assign o_state_dbg     = state_q;

endmodule
